// File: rtl/subtrai_serial.sv
// Bit-serial two's-complement subtractor, C = A - B, LSB first, one bit per clock.
// Optional build macro SUBTRAI_SAT_EN saturates C on signed overflow.
module subtrai_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] C,
  output logic             overflow,
  output logic             borrow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [WIDTH-1:0] res_n, c_n;
  logic [CW-1:0]    bitcnt;
  logic             bor_ff;
  logic             a_bit, b_bit, d, bout, ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      S_IDLE: if (start) state_n = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (bitcnt == LAST) state_n = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // One full-subtractor cell; the borrow chain lives in bor_ff.
  always_comb begin
    a_bit = a_sh[0];
    b_bit = b_sh[0];
    d     = a_bit ^ b_bit ^ bor_ff;
    bout  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bor_ff);
    res_n = {d, res[WIDTH-1:1]};
    ovf   = bor_ff ^ bout;
`ifdef SUBTRAI_SAT_EN
    // On the last bit a_bit is the minuend sign, which fixes the clamp direction.
    if (ovf) c_n = a_bit ? {1'b1, {(WIDTH-1){1'b0}}}
                         : {1'b0, {(WIDTH-1){1'b1}}};
    else     c_n = res_n;
`else
    c_n = res_n;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      bitcnt   <= '0;
      bor_ff   <= 1'b0;
      C        <= '0;
      overflow <= 1'b0;
      borrow   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh   <= A;
            b_sh   <= B;
            res    <= '0;
            bitcnt <= '0;
            bor_ff <= 1'b0;
          end
        end
        S_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res    <= res_n;
          bor_ff <= bout;
          bitcnt <= bitcnt + 1'b1;
          if (bitcnt == LAST) begin
            C        <= c_n;
            borrow   <= bout;
            overflow <= ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_subtrai_serial.sv
// Randomized self-checking bench for subtrai_serial (WIDTH=16).
// Reference model uses signed/unsigned integer arithmetic.
module tb_subtrai_serial;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a, b, c;
  logic         busy, done, overflow, borrow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  subtrai_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .A(a), .B(b),
    .busy(busy), .done(done), .C(c),
    .overflow(overflow), .borrow(borrow)
  );

  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] ec, output logic eo,
                                output logic eb);
    int sd;
    sd = int'($signed(x)) - int'($signed(y));
    eb = int'(x) < int'(y);
    eo = (sd > 32767) || (sd < -32768);
    ec = x - y;
`ifdef SUBTRAI_SAT_EN
    if (eo) ec = (sd > 0) ? 16'h7FFF : 16'h8000;
`endif
  endfunction

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL wait_done: done=%0b after %0d cycles, required 1", done, lat);
    end
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                       input string name);
    logic [W-1:0] ec;
    logic         eo, eb;
    int           lat;
    model(x, y, ec, eo, eb);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL %s busy: got %0b required 1", name, busy);
    end
    wait_done(lat);
    tests++;
    if (lat != W) begin
      fails++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, W);
    end
    tests++;
    if (c !== ec || overflow !== eo || borrow !== eb) begin
      fails++;
      $display("FAIL %s result: got C=%h ov=%b bo=%b required C=%h ov=%b bo=%b",
               name, c, overflow, borrow, ec, eo, eb);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || c !== ec) begin
      fails++;
      $display("FAIL %s hold: got done=%b C=%h required done=0 C=%h",
               name, done, c, ec);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #12;
    tests++;
    if ({busy, done, overflow, borrow} !== 4'b0 || c !== '0) begin
      fails++;
      $display("FAIL reset: got busy=%b done=%b C=%h ov=%b bo=%b required all 0",
               busy, done, c, overflow, borrow);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed;
    do_op(16'h0005, 16'h0003, "dir_5_3");
    do_op(16'h0000, 16'h0001, "dir_0_1");
    do_op(16'h8000, 16'h0001, "dir_min_1");
    do_op(16'h7FFF, 16'hFFFF, "dir_max_m1");
    do_op(16'h1234, 16'h1234, "dir_equal");
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++)
      do_op(W'($urandom), W'($urandom), "random");
  endtask

  task automatic test_start_ignored;
    logic [W-1:0] ec, x, y;
    logic         eo, eb;
    int           n, pulses;
    x = 16'h4321; y = 16'hA5A5;
    model(x, y, ec, eo, eb);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    a = 16'h0001; b = 16'h7000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0;
    for (n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        tests++;
        if (c !== ec || overflow !== eo || borrow !== eb) begin
          fails++;
          $display("FAIL ignore result: got C=%h ov=%b bo=%b required C=%h ov=%b bo=%b",
                   c, overflow, borrow, ec, eo, eb);
        end
      end
    end
    tests++;
    if (pulses != 1) begin
      fails++;
      $display("FAIL ignore pulses: got %0d required 1", pulses);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    tests++;
    if ({busy, done, overflow, borrow} !== 4'b0 || c !== '0) begin
      fails++;
      $display("FAIL reset_mid: got busy=%b done=%b C=%h ov=%b bo=%b required all 0",
               busy, done, c, overflow, borrow);
    end
    @(negedge clk); rst = 1'b0;
    do_op(16'h0100, 16'h0200, "after_reset");
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] e1, e2;
    logic         o1, o2, b1, b2;
    int           lat, n;
    model(16'h9000, 16'h1000, e1, o1, b1);
    model(16'h0003, 16'h8000, e2, o2, b2);
    @(negedge clk);
    a = 16'h9000; b = 16'h1000; start = 1'b1;
    @(posedge clk); #1;
    a = 16'h0003; b = 16'h8000;
    wait_done(lat);
    tests++;
    if (lat != W || c !== e1 || overflow !== o1 || borrow !== b1) begin
      fails++;
      $display("FAIL b2b first: got lat=%0d C=%h ov=%b bo=%b required lat=%0d C=%h ov=%b bo=%b",
               lat, c, overflow, borrow, W, e1, o1, b1);
    end
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 60);
    start = 1'b0;
    tests++;
    if (n != W + 2 || c !== e2 || overflow !== o2 || borrow !== b2) begin
      fails++;
      $display("FAIL b2b second: got gap=%0d C=%h ov=%b bo=%b required gap=%0d C=%h ov=%b bo=%b",
               n, c, overflow, borrow, W + 2, e2, o2, b2);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
